// File: rtl/trng_health_pkg.sv
// Shared constants for the TRNG health-test FIFO: state encodings, default
// cutoffs and a constant clog2 helper.
package trng_health_pkg;

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_STARTUP = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_ALARM   = 2'd3;

  localparam int DEF_RCT_CUTOFF    = 4;
  localparam int DEF_APT_WINDOW    = 64;
  localparam int DEF_APT_CUTOFF    = 13;
  localparam int DEF_STARTUP_BYTES = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock show-ahead FIFO with flush; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module trng_sync_fifo
  import trng_health_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DW-1:0]           wdata,
  input  logic                    pop,
  output logic [DW-1:0]           rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop;

  assign full   = (r_level == LW'(DEPTH));
  assign empty  = (r_level == '0);
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign rdata  = r_mem[r_rd_ptr];
  assign level  = r_level;

  // Memory is reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

endmodule

// File: rtl/trng_health_fifo.sv
// TRNG output stage: RCT/APT online health tests, startup qualification and a
// show-ahead output FIFO. Optional drop counter: TRNG_HEALTH_DROP_CNT_EN.
module trng_health_fifo
  import trng_health_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW    = DEF_APT_WINDOW,
  parameter int APT_CUTOFF    = DEF_APT_CUTOFF,
  parameter int STARTUP_BYTES = DEF_STARTUP_BYTES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic                        clear_i,
  input  logic                        in_valid_i,
  input  logic [DATA_WIDTH-1:0]       in_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        alarm_o,
  output logic                        rct_fail_o,
  output logic                        apt_fail_o,
  output logic                        run_o,
  output logic [clog2(FIFO_DEPTH):0]  level_o
`ifdef TRNG_HEALTH_DROP_CNT_EN
  ,output logic [15:0]                drop_cnt_o
`endif
);

  localparam int RCW = clog2(RCT_CUTOFF + 1);
  localparam int AIW = clog2(APT_WINDOW);
  localparam int ACW = clog2(APT_CUTOFF + 1);
  localparam int SCW = clog2(STARTUP_BYTES + 1);

  logic [1:0]            r_state;
  logic [SCW-1:0]        r_su_cnt;
  logic                  r_alarm, r_rct_fail, r_apt_fail;

  logic                  r_rct_seen;
  logic [DATA_WIDTH-1:0] r_rct_last;
  logic [RCW-1:0]        r_rct_cnt;
  logic [AIW-1:0]        r_apt_idx;
  logic [DATA_WIDTH-1:0] r_apt_ref;
  logic [ACW-1:0]        r_apt_cnt;

  logic                  w_acc, w_test_rst;
  logic [RCW-1:0]        w_rct_next;
  logic [ACW-1:0]        w_apt_next;
  logic                  w_rct_fail, w_apt_fail, w_fail;
  logic                  w_push, w_wr, w_pop, w_flush;
  logic                  w_full, w_empty;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [clog2(FIFO_DEPTH):0] w_level;

  assign w_acc      = in_valid_i & en_i & ((r_state == ST_STARTUP) | (r_state == ST_RUN));
  assign w_test_rst = ~en_i | (r_state == ST_OFF) | ((r_state == ST_ALARM) & clear_i);

  assign w_rct_next = (r_rct_seen && (in_data_i == r_rct_last)) ? r_rct_cnt + 1'b1 : RCW'(1);
  assign w_apt_next = (r_apt_idx == '0) ? ACW'(1)
                                        : r_apt_cnt + ACW'(in_data_i == r_apt_ref);
  assign w_rct_fail = w_acc & (w_rct_next == RCW'(RCT_CUTOFF));
  assign w_apt_fail = w_acc & (w_apt_next == ACW'(APT_CUTOFF));
  assign w_fail     = w_rct_fail | w_apt_fail;

  // A failing byte is never stored; alarm entry flushes in the same edge.
  assign w_push  = w_acc & (r_state == ST_RUN) & ~w_fail;
  assign w_pop   = out_valid_o & out_ready_i;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_flush = ~en_i | w_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rct_seen <= 1'b0;
      r_rct_last <= '0;
      r_rct_cnt  <= '0;
      r_apt_idx  <= '0;
      r_apt_ref  <= '0;
      r_apt_cnt  <= '0;
    end else if (w_test_rst) begin
      r_rct_seen <= 1'b0;
      r_rct_last <= '0;
      r_rct_cnt  <= '0;
      r_apt_idx  <= '0;
      r_apt_ref  <= '0;
      r_apt_cnt  <= '0;
    end else if (w_acc) begin
      r_rct_seen <= 1'b1;
      r_rct_last <= in_data_i;
      r_rct_cnt  <= w_rct_next;
      r_apt_idx  <= r_apt_idx + 1'b1;
      r_apt_cnt  <= w_apt_next;
      if (r_apt_idx == '0) r_apt_ref <= in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_su_cnt   <= '0;
      r_alarm    <= 1'b0;
      r_rct_fail <= 1'b0;
      r_apt_fail <= 1'b0;
    end else if (!en_i) begin
      r_state    <= ST_OFF;
      r_su_cnt   <= '0;
      r_alarm    <= 1'b0;
      r_rct_fail <= 1'b0;
      r_apt_fail <= 1'b0;
    end else begin
      if (w_fail) begin
        r_state    <= ST_ALARM;
        r_alarm    <= 1'b1;
        r_rct_fail <= w_rct_fail;
        r_apt_fail <= w_apt_fail;
      end else begin
        case (r_state)
          ST_OFF: begin
            r_state  <= ST_STARTUP;
            r_su_cnt <= '0;
          end
          ST_STARTUP: if (w_acc) begin
            if (r_su_cnt == SCW'(STARTUP_BYTES - 1)) r_state <= ST_RUN;
            else                                     r_su_cnt <= r_su_cnt + 1'b1;
          end
          ST_ALARM: if (clear_i) begin
            r_state    <= ST_STARTUP;
            r_su_cnt   <= '0;
            r_alarm    <= 1'b0;
            r_rct_fail <= 1'b0;
            r_apt_fail <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  trng_sync_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (w_flush),
    .push  (w_wr),
    .wdata (in_data_i),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign run_o       = (r_state == ST_RUN);
  assign out_valid_o = run_o & ~w_empty;
  assign out_data_o  = w_rdata;
  assign level_o     = w_level;
  assign alarm_o     = r_alarm;
  assign rct_fail_o  = r_rct_fail;
  assign apt_fail_o  = r_apt_fail;

`ifdef TRNG_HEALTH_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = w_push & ~w_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_drop_cnt <= '0;
    else if (~en_i | ((r_state == ST_ALARM) & clear_i)) r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF))     r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_trng_health_fifo.sv
// Scoreboard bench for trng_health_fifo: directed byte streams, expected pops
// queued at stimulus time and compared by an independent monitor.
module tb_trng_health_fifo;

  logic       clk = 1'b0;
  logic       rst, en, clear, in_valid, out_ready;
  logic [7:0] in_data;
  logic       out_valid, alarm, rct_fail, apt_fail, run;
  logic [7:0] out_data;
  logic [4:0] level;
`ifdef TRNG_HEALTH_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  trng_health_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .alarm_o     (alarm),
    .rct_fail_o  (rct_fail),
    .apt_fail_o  (apt_fail),
    .run_o       (run),
    .level_o     (level)
`ifdef TRNG_HEALTH_DROP_CNT_EN
    ,.drop_cnt_o (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    out_ready = 1'b1;
    for (k = 0; k < 40; k++) begin
      if (level == 0) break;
      tick();
    end
    out_ready = 1'b0;
    chk("drain level", level, 0);
    chk("drain queue left", exp_q.size(), 0);
  endtask

  // Monitor: sample between edges, when a pop will occur at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop: got %0h with no expected byte", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL pop: got %0h expected %0h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset run", run, 0);
    chk("reset alarm", alarm, 0);
    chk("reset rct", rct_fail, 0);
    chk("reset apt", apt_fail, 0);
    chk("reset level", level, 0);
    chk("reset valid", out_valid, 0);
    chk("reset data", out_data, 0);
`ifdef TRNG_HEALTH_DROP_CNT_EN
    chk("reset drop", drop_cnt, 0);
`endif

    // Startup: 64 distinct bytes, nothing visible until RUN.
    rst = 1'b0; en = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      send(8'(i));
      chk("startup valid", out_valid, 0);
      if (i == 62) chk("run before 64th", run, 0);
    end
    chk("run after 64th", run, 1);

    exp_q.push_back(8'h55);
    send(8'h55);
    chk("first valid", out_valid, 1);
    chk("first data", out_data, 8'h55);
    drain();

    // RCT: fourth identical byte fails and flushes the three buffered ones.
    send(8'hA5); send(8'hA5); send(8'hA5);
    chk("rct level pre", level, 3);
    chk("rct alarm pre", alarm, 0);
    send(8'hA5);
    chk("rct alarm", alarm, 1);
    chk("rct flag", rct_fail, 1);
    chk("rct apt flag", apt_fail, 0);
    chk("rct level", level, 0);
    chk("rct valid", out_valid, 0);
    chk("rct run", run, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear alarm", alarm, 0);
    chk("clear rct", rct_fail, 0);
    chk("clear run", run, 0);

    // APT: ref 0x3C at even positions 0..24 -> 13th match at position 24.
    for (int i = 0; i < 25; i++) begin
      send((i % 2 == 0) ? 8'h3C : 8'(8'h80 + i));
      if (i == 22) chk("apt alarm at 12", alarm, 0);
    end
    chk("apt alarm", alarm, 1);
    chk("apt flag", apt_fail, 1);
    chk("apt rct flag", rct_fail, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("apt clear", apt_fail, 0);

    for (int i = 0; i < 64; i++) send(8'(i));
    chk("rerun", run, 1);

    // Fill beyond depth with consumer stalled: last 4 dropped.
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h40 + i));
      send(8'(8'h40 + i));
      if (i == 15) chk("full level 16", level, 16);
    end
    chk("full level 20", level, 16);
    chk("full alarm", alarm, 0);
`ifdef TRNG_HEALTH_DROP_CNT_EN
    chk("drop cnt", drop_cnt, 4);
`endif

    // Push and pop together on a full FIFO.
    exp_q.push_back(8'h60);
    out_ready = 1'b1;
    send(8'h60);
    out_ready = 1'b0;
    chk("pushpop level", level, 16);
`ifdef TRNG_HEALTH_DROP_CNT_EN
    chk("pushpop drop", drop_cnt, 4);
`endif
    drain();

    // Disable with data buffered.
    for (int i = 0; i < 5; i++) send(8'(8'h70 + i));
    chk("buffered 5", level, 5);
    en = 1'b0;
    tick();
    chk("disable level", level, 0);
    chk("disable run", run, 0);
    chk("disable valid", out_valid, 0);
    chk("disable alarm", alarm, 0);
    chk("final queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
